// File: rtl/s3g_tx.sv
// s3g_tx: S3G packet transmitter.
// Frames the contents of a 256x8 payload RAM as SYNC, LEN, payload bytes and
// CRC-8 (Maxim, reflected 0x31, init 0x00, payload only). It hands the frame
// one byte at a time to a UART through a tx_start/tx_busy handshake.
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   wr_en/addr/data   : payload RAM write port (ignored while busy)
//   send, send_len    : start strobe and payload length (sampled while idle)
//   busy, packet_sent : frame in flight / one-cycle completion pulse
//   tx_data, tx_start : registered byte and load strobe to the UART
//   tx_busy           : UART busy indication
module s3g_tx #(
    parameter logic [7:0] SYNC_BYTE = 8'hD5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       send,
    input  logic [7:0] send_len,
    output logic       busy,
    output logic       packet_sent,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CRC  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic [7:0] crc_q, crc_d;
    logic       busy_q, busy_d;
    logic       packet_sent_q, packet_sent_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;

    logic [7:0] mem [256];
    logic [7:0] rd_data_q;
    logic       tx_ready;

    // Bit-serial reflected CRC-8 step over one byte, LSB first.
    function automatic logic [7:0] nextCRC8_D8(input logic [7:0] data, input logic [7:0] crc);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[0] ^ data[i];
            c  = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
        end
        return c;
    endfunction

    // The cycle after a tx_start is a guard cycle: it gives the UART time to
    // raise tx_busy and covers the one-cycle RAM read latency after rd_addr moves.
    assign tx_ready = !tx_busy && !tx_start_q;

    // Payload RAM; writes are locked out while a frame is in flight.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[rd_addr_q];
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        rd_addr_d     = rd_addr_q;
        crc_d         = crc_q;
        busy_d        = busy_q;
        packet_sent_d = 1'b0;
        tx_data_d     = tx_data_q;
        tx_start_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (send) begin
                    len_d     = send_len;
                    crc_d     = '0;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SYNC;
                end
            end
            S_SYNC: begin
                if (tx_ready) begin
                    tx_data_d  = SYNC_BYTE;
                    tx_start_d = 1'b1;
                    state_d    = S_LEN;
                end
            end
            S_LEN: begin
                if (tx_ready) begin
                    tx_data_d  = len_q;
                    tx_start_d = 1'b1;
                    cnt_d      = len_q;
                    state_d    = (len_q == 8'd0) ? S_CRC : S_DATA;
                end
            end
            S_DATA: begin
                if (tx_ready) begin
                    tx_data_d  = rd_data_q;
                    tx_start_d = 1'b1;
                    crc_d      = nextCRC8_D8(rd_data_q, crc_q);
                    rd_addr_d  = rd_addr_q + 8'd1;
                    cnt_d      = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = S_CRC;
                    end
                end
            end
            S_CRC: begin
                if (tx_ready) begin
                    tx_data_d  = crc_q;
                    tx_start_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (tx_ready) begin
                    packet_sent_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            cnt_q         <= '0;
            rd_addr_q     <= '0;
            crc_q         <= '0;
            busy_q        <= 1'b0;
            packet_sent_q <= 1'b0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            cnt_q         <= cnt_d;
            rd_addr_q     <= rd_addr_d;
            crc_q         <= crc_d;
            busy_q        <= busy_d;
            packet_sent_q <= packet_sent_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= tx_start_d;
        end
    end

    assign busy        = busy_q;
    assign packet_sent = packet_sent_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = tx_start_q;

endmodule

// File: tb/tb_s3g_tx.sv
// Directed bench for s3g_tx: table of packets plus hand-written corner sequences.
module tb_s3g_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       send = 1'b0;
    logic [7:0] send_len = '0;
    logic       busy;
    logic       packet_sent;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;

    s3g_tx #(.SYNC_BYTE(8'hD5)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .send(send), .send_len(send_len), .busy(busy), .packet_sent(packet_sent),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // UART model and monitor, sampled on the falling edge.
    logic [7:0] cap_q[$];
    logic [7:0] exp_q[$];
    int  cyc = 0;
    int  ack_cycles = 0;
    bit  hold_busy = 1'b0;
    int  busy_cnt = 0;
    int  sent_cnt = 0;
    int  spacing_err = 0;
    int  busy_low_err = 0;
    int  last_start = 0;
    bit  have_last = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_start) begin
            cap_q.push_back(tx_data);
            if (have_last && (cyc - last_start) < 2) spacing_err++;
            if (!busy) busy_low_err++;
            last_start = cyc;
            have_last  = 1'b1;
            busy_cnt   = ack_cycles;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = hold_busy || (busy_cnt > 0);
        if (packet_sent) sent_cnt++;
    end

    function automatic logic [7:0] ref_crc(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in ^ d;
        for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] len, input bit with_wr,
                            input logic [7:0] a, input logic [7:0] d);
        send = 1'b1; send_len = len;
        if (with_wr) begin
            wr_en = 1'b1; wr_addr = a; wr_data = d;
        end
        step();
        send = 1'b0; wr_en = 1'b0;
        check("busy_after_send", busy, 1);
    endtask

    // Wait for the completion pulse; busy must stay high until it comes.
    task automatic wait_sent(input string name, input int start, input int budget);
        int n;
        int gaps;
        n = 0; gaps = 0;
        while (sent_cnt == start && n < budget) begin
            if (!busy) gaps++;
            step();
            n++;
        end
        if (sent_cnt == start) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no packet_sent expected one within %0d cycles", name, budget);
        end else begin
            check({name, "_busy_gap"}, gaps, 0);
            check({name, "_sent_pulse"}, packet_sent, 1);
            check({name, "_busy_drop"}, busy, 0);
            step();
            check({name, "_sent_once"}, sent_cnt, start + 1);
            check({name, "_sent_low"}, packet_sent, 0);
        end
    endtask

    task automatic wait_bytes(input int nb, input int budget);
        int n;
        n = 0;
        while (cap_q.size() < nb && n < budget) begin
            step();
            n++;
        end
        if (cap_q.size() < nb) begin
            checks++; errors++;
            $display("FAIL wait_bytes: got %0d bytes expected %0d", cap_q.size(), nb);
        end
    endtask

    task automatic check_frame(input string name);
        check({name, "_nbytes"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), cap_q[i], exp_q[i]);
    endtask

    typedef struct {
        int         len;
        logic [7:0] pl[9];
        int         ack;
        bit         wr_with_send;
        logic [7:0] crc;
    } vec_t;

    vec_t vt[5];

    initial begin
        int s;
        int nb;
        logic [7:0] c;

        // len, payload, UART ack cycles, write-with-send, expected CRC
        vt[0] = '{1, '{8'h01, 0, 0, 0, 0, 0, 0, 0, 0}, 10, 1'b0, 8'h5E};
        vt[1] = '{0, '{0, 0, 0, 0, 0, 0, 0, 0, 0},      3, 1'b0, 8'h00};
        vt[2] = '{2, '{8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 8'hC4};
        vt[3] = '{9, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, 4, 1'b0, 8'hA1};
        vt[4] = '{1, '{8'hFF, 0, 0, 0, 0, 0, 0, 0, 0},  1, 1'b1, 8'h35};

        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_packet_sent", packet_sent, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        rst = 1'b0;
        step();

        for (int k = 0; k < 5; k++) begin
            ack_cycles = vt[k].ack;
            for (int i = 0; i < vt[k].len; i++)
                if (!(vt[k].wr_with_send && i == vt[k].len - 1))
                    wr_byte(8'(i), vt[k].pl[i]);
            cap_q.delete();
            exp_q.delete();
            exp_q.push_back(8'hD5);
            exp_q.push_back(8'(vt[k].len));
            for (int i = 0; i < vt[k].len; i++) exp_q.push_back(vt[k].pl[i]);
            exp_q.push_back(vt[k].crc);
            s = sent_cnt;
            send_pkt(8'(vt[k].len), vt[k].wr_with_send, 8'(vt[k].len - 1), vt[k].pl[vt[k].len > 0 ? vt[k].len - 1 : 0]);
            wait_sent($sformatf("vec%0d", k), s, 500);
            check_frame($sformatf("vec%0d", k));
            repeat (3) step();
        end

        // UART stalls for 50 cycles in the middle of the payload.
        wr_byte(8'h00, 8'h31);
        ack_cycles = 2;
        cap_q.delete();
        s = sent_cnt;
        send_pkt(8'd9, 1'b0, 8'h00, 8'h00);
        wait_bytes(5, 200);
        hold_busy = 1'b1;
        repeat (50) step();
        check("hold_no_start", cap_q.size(), 5);
        check("hold_tx_data", tx_data, 8'h33);
        check("hold_busy", busy, 1);
        hold_busy = 1'b0;
        wait_sent("hold", s, 500);
        exp_q.delete();
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'h09);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h31 + i));
        exp_q.push_back(8'hA1);
        check_frame("hold");
        repeat (3) step();

        // send and RAM write while busy are both ignored.
        wr_byte(8'h00, 8'h01);
        ack_cycles = 10;
        cap_q.delete();
        s = sent_cnt;
        send_pkt(8'd1, 1'b0, 8'h00, 8'h00);
        repeat (3) step();
        send = 1'b1; send_len = 8'd7;
        wr_en = 1'b1; wr_addr = 8'h00; wr_data = 8'hFF;
        step();
        send = 1'b0; wr_en = 1'b0;
        wait_sent("ignore", s, 500);
        exp_q.delete();
        exp_q.push_back(8'hD5); exp_q.push_back(8'h01);
        exp_q.push_back(8'h01); exp_q.push_back(8'h5E);
        check_frame("ignore");
        repeat (40) step();
        check("ignore_not_queued", cap_q.size(), 4);
        check("ignore_idle", busy, 0);

        // Reset in the middle of an 8-byte packet.
        for (int i = 0; i < 8; i++) wr_byte(8'(i), 8'(8'hA0 + i));
        ack_cycles = 3;
        cap_q.delete();
        s = sent_cnt;
        send_pkt(8'd8, 1'b0, 8'h00, 8'h00);
        wait_bytes(3, 200);
        check("pre_rst_tx_start", tx_start, 1);
        rst = 1'b1;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_tx_data", tx_data, 0);
        check("midrst_packet_sent", packet_sent, 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        check("midrst_no_sent", sent_cnt, s);
        cap_q.delete();
        send_pkt(8'd1, 1'b0, 8'h00, 8'h00);
        wait_sent("after_rst", s, 500);
        exp_q.delete();
        exp_q.push_back(8'hD5); exp_q.push_back(8'h01);
        exp_q.push_back(8'hA0); exp_q.push_back(ref_crc(8'h00, 8'hA0));
        check_frame("after_rst");
        repeat (3) step();

        // Maximum length packet.
        for (int i = 0; i < 256; i++) wr_byte(8'(i), 8'(i));
        ack_cycles = 1;
        cap_q.delete();
        exp_q.delete();
        exp_q.push_back(8'hD5);
        exp_q.push_back(8'hFF);
        c = 8'h00;
        for (int i = 0; i < 255; i++) begin
            exp_q.push_back(8'(i));
            c = ref_crc(c, 8'(i));
        end
        exp_q.push_back(c);
        s = sent_cnt;
        send_pkt(8'hFF, 1'b0, 8'h00, 8'h00);
        wait_sent("len255", s, 5000);
        nb = cap_q.size();
        check("len255_count", nb, 258);
        check_frame("len255");

        check("start_spacing", spacing_err, 0);
        check("start_while_idle", busy_low_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
